// File: rtl/mdl_modeseq.sv
// Power-up mode sequencer: waits for bootloader sync, counts bootloader
// pages, then issues the one-tick command-register-reset / BDI-enable pulse
// pair that hands the mode flag latches over to user mode.
//
// Handshake note: there is no valid/ready pair here. Every input is
// qualified by the 2M tick (i_CLK2M_PCEN_n = 0 on an i_MCLK rising edge) and
// is a don't-care on any other edge. All outputs are registers that only
// update on ticks, so each active-low pulse spans exactly one tick interval.
// o_STATE exposes the FSM state for debug and monitoring.
module mdl_modeseq #(
   parameter int BOOT_PAGES   = 2,
   parameter int SYNC_TIMEOUT = 4095,
   parameter int CNT_W        = 12
) (
   input  logic       i_MCLK,
   input  logic       i_SYS_RST_n,
   input  logic       i_CLK2M_PCEN_n,
   input  logic       i_SYS_RUN_FLAG,
   input  logic       i_SYNC_DET,
   input  logic       i_PAGE_DONE,
   input  logic       i_RETRY,
   output logic       o_SYNCED_FLAG_SET_n,
   output logic       o_CMDREG_RST_n,
   output logic       o_BDI_EN_SET_n,
   output logic [2:0] o_STATE,
   output logic [7:0] o_PAGE_CNT,
   output logic       o_BOOT_ERR,
   output logic       o_USER_RDY
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SYNC_WAIT = 3'd1,
      ST_BOOT_LOAD = 3'd2,
      ST_HANDOVER  = 3'd3,
      ST_USER      = 3'd4,
      ST_ERROR     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(SYNC_TIMEOUT);
   localparam logic [7:0]       PAGE_LIM   = 8'(BOOT_PAGES);
   localparam logic [7:0]       PAGE_MAX   = 8'hFF;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       page_q, page_d;
   logic             synced_n_q, synced_n_d;
   logic             handover_n_q, handover_n_d;
   logic             err_q, err_d;
   logic             rdy_q, rdy_d;
   logic             tick;

   assign tick = ~i_CLK2M_PCEN_n;

   // Next-state, counter and registered-output decode; evaluated every
   // MCLK but only committed on ticks.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      page_d  = page_q;

      case (state_q)
         ST_IDLE: begin
            if (i_SYS_RUN_FLAG) begin
               state_d = ST_SYNC_WAIT;
               cnt_d   = '0;
               page_d  = '0;
            end
         end
         ST_SYNC_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Sync takes precedence over a timeout on the same tick.
            if (i_SYNC_DET) begin
               state_d = ST_BOOT_LOAD;
            end else if (cnt_d == TO_LIM) begin
               state_d = ST_ERROR;
            end
         end
         ST_BOOT_LOAD: begin
            if (i_PAGE_DONE && (page_q != PAGE_MAX)) begin
               page_d = page_q + 8'd1;
               if (page_d == PAGE_LIM) begin
                  state_d = ST_HANDOVER;
               end
            end
         end
         ST_HANDOVER: begin
            state_d = ST_USER;
         end
         ST_USER: begin
            state_d = ST_USER;
         end
         ST_ERROR: begin
            if (i_RETRY) begin
               state_d = ST_SYNC_WAIT;
               cnt_d   = '0;
               page_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            page_d  = '0;
         end
      endcase

      // Losing run aborts the sequence from anywhere and wins over all else.
      if (!i_SYS_RUN_FLAG && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         page_d  = '0;
      end

      // Pulses are derived from the committed transition, so an aborted
      // transition never produces a pulse.
      synced_n_d   = !((state_q == ST_SYNC_WAIT) && (state_d == ST_BOOT_LOAD));
      handover_n_d = (state_d != ST_HANDOVER);
      err_d        = (state_d == ST_ERROR);
      rdy_d        = (state_d == ST_USER);
   end

   // State, counters and output registers; advance only on ticks.
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
      if (!i_SYS_RST_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         page_q       <= '0;
         synced_n_q   <= 1'b1;
         handover_n_q <= 1'b1;
         err_q        <= 1'b0;
         rdy_q        <= 1'b0;
      end else if (tick) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         page_q       <= page_d;
         synced_n_q   <= synced_n_d;
         handover_n_q <= handover_n_d;
         err_q        <= err_d;
         rdy_q        <= rdy_d;
      end
   end

   // One register drives both handover strobes so they can never skew.
   assign o_SYNCED_FLAG_SET_n = synced_n_q;
   assign o_CMDREG_RST_n      = handover_n_q;
   assign o_BDI_EN_SET_n      = handover_n_q;
   assign o_STATE             = state_q;
   assign o_PAGE_CNT          = page_q;
   assign o_BOOT_ERR          = err_q;
   assign o_USER_RDY          = rdy_q;

endmodule
